// File: rtl/load_store_unit.sv
// Load/store unit: turns a single-cycle load/store request into a valid/ready bus access with byte strobes,
// load extension, core stall and a wait timeout. Define LSU_MISALIGN_EN to trap misaligned accesses without a bus cycle.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req,
    input  logic        memwrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] readdata,
    output logic        stall,
    output logic        bus_err,
    output logic        misalign,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] readdata_q, readdata_d;
    logic        err_q, err_d;
    logic        mis_q, mis_d;

    logic [31:0] lane_wdata;
    logic [3:0]  lane_wstrb;
    logic [31:0] load_ext;
    logic [31:0] byte_word;
    logic [15:0] half_sel;
    logic        misaligned_req;

    // funct3[1:0]: 00 byte, 01 half, anything else is treated as a full word
    always_comb begin
        lane_wdata = wdata;
        lane_wstrb = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                lane_wdata = {4{wdata[7:0]}};
                lane_wstrb = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                lane_wdata = {2{wdata[15:0]}};
                lane_wstrb = 4'b0011 << {addr[1], 1'b0};
            end
            default: begin
                lane_wdata = wdata;
                lane_wstrb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        byte_word = bus_rdata >> {addr_q[1:0], 3'b000};
        half_sel  = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{byte_word[7]}}, byte_word[7:0]};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_ext = {24'h0, byte_word[7:0]};
            3'b101:  load_ext = {16'h0, half_sel};
            default: load_ext = bus_rdata;
        endcase
    end

`ifdef LSU_MISALIGN_EN
    assign misaligned_req = ((funct3[1:0] == 2'b01) && addr[0]) ||
                            (funct3[1] && (addr[1:0] != 2'b00));
`else
    assign misaligned_req = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        funct3_d   = funct3_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        cnt_d      = cnt_q;
        readdata_d = readdata_q;
        err_d      = 1'b0;
        mis_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    addr_d   = addr;
                    funct3_d = funct3;
                    we_d     = memwrite;
                    wdata_d  = lane_wdata;
                    wstrb_d  = memwrite ? lane_wstrb : 4'b0000;
                    cnt_d    = 8'd0;
                    if (misaligned_req) begin
                        state_d    = DONE;
                        mis_d      = 1'b1;
                        readdata_d = 32'h0;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (bus_ready) begin
                    state_d    = DONE;
                    readdata_d = we_q ? 32'h0 : load_ext;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d    = DONE;
                    err_d      = 1'b1;
                    readdata_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= 32'h0;
            funct3_q   <= 3'b000;
            we_q       <= 1'b0;
            wdata_q    <= 32'h0;
            wstrb_q    <= 4'b0000;
            cnt_q      <= 8'd0;
            readdata_q <= 32'h0;
            err_q      <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            funct3_q   <= funct3_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            cnt_q      <= cnt_d;
            readdata_q <= readdata_d;
            err_q      <= err_d;
            mis_q      <= mis_d;
        end
    end

    assign stall     = ((state_q == IDLE) && mem_req) || (state_q == BUSY);
    assign bus_valid = (state_q == BUSY);
    assign bus_we    = we_q;
    assign bus_addr  = {addr_q[31:2], 2'b00};
    assign bus_wdata = wdata_q;
    assign bus_wstrb = wstrb_q;
    assign readdata  = readdata_q;
    assign bus_err   = err_q;
    assign misalign  = mis_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit: loads, stores, wait states, timeout, async reset and
// the misaligned-word case (expectation follows LSU_MISALIGN_EN).
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic        memwrite;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] readdata;
    logic        stall;
    logic        bus_err;
    logic        misalign;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    int checks   = 0;
    int failures = 0;

    int          res_done_cyc;
    int          res_stall_cycles;
    int          res_valid_cycles;
    logic [31:0] res_rdata;
    logic [31:0] res_bus_addr;
    logic [31:0] res_bus_wdata;
    logic [3:0]  res_wstrb;
    logic        res_we;
    logic        res_err;
    logic        res_mis;

    load_store_unit #(.TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .memwrite  (memwrite),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .readdata  (readdata),
        .stall     (stall),
        .bus_err   (bus_err),
        .misalign  (misalign),
        .bus_valid (bus_valid),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_wstrb (bus_wstrb),
        .bus_ready (bus_ready),
        .bus_rdata (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One access with a simple bus responder: ready after 'waits' BUSY cycles, never if waits < 0.
    task automatic run_access(input string name, input logic we, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input int waits);
        int left;
        bit done;
        @(negedge clk);
        mem_req   = 1'b1;
        memwrite  = we;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        bus_rdata = rd;
        bus_ready = 1'b0;
        left = waits;
        done = 1'b0;
        res_done_cyc = -1;
        res_stall_cycles = 0;
        res_valid_cycles = 0;
        res_rdata = 32'h0;
        res_bus_addr = 32'h0;
        res_bus_wdata = 32'h0;
        res_wstrb = 4'h0;
        res_we = 1'b0;
        res_err = 1'b0;
        res_mis = 1'b0;
        #1;
        for (int k = 0; k < 64 && !done; k++) begin
            if (k > 0 && !stall) begin
                done = 1'b1;
                res_done_cyc = k;
                res_rdata = readdata;
                res_err = bus_err;
                res_mis = misalign;
                mem_req = 1'b0;
            end else begin
                if (stall) res_stall_cycles++;
                if (bus_valid) begin
                    res_valid_cycles++;
                    res_bus_addr  = bus_addr;
                    res_bus_wdata = bus_wdata;
                    res_wstrb     = bus_wstrb;
                    res_we        = bus_we;
                    bus_ready     = (left == 0);
                    if (left > 0) left--;
                end else begin
                    bus_ready = 1'b0;
                end
                @(negedge clk);
            end
        end
        bus_ready = 1'b0;
        mem_req = 1'b0;
        check_eq({name, "_completes"}, 32'(done), 32'd1);
        $display("access %s: done_cyc=%0d stall=%0d addr=%h wdata=%h strb=%b we=%0d rdata=%h err=%0d mis=%0d",
                 name, res_done_cyc, res_stall_cycles, res_bus_addr, res_bus_wdata, res_wstrb,
                 res_we, res_rdata, res_err, res_mis);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        mem_req = 1'b0;
        memwrite = 1'b0;
        funct3 = 3'b000;
        addr = 32'h0;
        wdata = 32'h0;
        bus_ready = 1'b0;
        bus_rdata = 32'h0;

        // Reset state
        @(negedge clk);
        check_eq("rst_valid", 32'(bus_valid), 32'd0);
        check_eq("rst_we", 32'(bus_we), 32'd0);
        check_eq("rst_addr", bus_addr, 32'h0);
        check_eq("rst_wdata", bus_wdata, 32'h0);
        check_eq("rst_wstrb", 32'(bus_wstrb), 32'd0);
        check_eq("rst_readdata", readdata, 32'h0);
        check_eq("rst_err", 32'(bus_err), 32'd0);
        check_eq("rst_mis", 32'(misalign), 32'd0);
        check_eq("rst_stall_idle", 32'(stall), 32'd0);
        mem_req = 1'b1;
        #1;
        check_eq("rst_stall_follows_req", 32'(stall), 32'd1);
        mem_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // LB, sign extension of byte 3
        run_access("lb", 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0);
        check_eq("lb_addr", res_bus_addr, 32'h0000_0100);
        check_eq("lb_rdata", res_rdata, 32'hFFFF_FF80);
        check_eq("lb_stall", 32'(res_stall_cycles), 32'd2);
        check_eq("lb_done_cyc", 32'(res_done_cyc), 32'd2);
        check_eq("lb_strb", 32'(res_wstrb), 32'd0);

        // SB to lane 3
        run_access("sb", 1'b1, 3'b000, 32'h0000_0007, 32'h0000_00A5, 32'h0, 0);
        check_eq("sb_we", 32'(res_we), 32'd1);
        check_eq("sb_strb", 32'(res_wstrb), 32'h8);
        check_eq("sb_wdata", res_bus_wdata, 32'hA5A5_A5A5);
        check_eq("sb_addr", res_bus_addr, 32'h0000_0004);
        check_eq("sb_rdata", res_rdata, 32'h0);

        // LHU with 3 wait cycles
        run_access("lhu", 1'b0, 3'b101, 32'h0000_0202, 32'h0, 32'hBEEF_0000, 3);
        check_eq("lhu_rdata", res_rdata, 32'h0000_BEEF);
        check_eq("lhu_stall", 32'(res_stall_cycles), 32'd5);
        check_eq("lhu_addr", res_bus_addr, 32'h0000_0200);

        // SH to upper half with 1 wait cycle
        run_access("sh", 1'b1, 3'b001, 32'h0000_0006, 32'h1234_BEEF, 32'h0, 1);
        check_eq("sh_strb", 32'(res_wstrb), 32'hC);
        check_eq("sh_wdata", res_bus_wdata, 32'hBEEF_BEEF);
        check_eq("sh_stall", 32'(res_stall_cycles), 32'd3);

        // LH sign extension, lower half
        run_access("lh", 1'b0, 3'b001, 32'h0000_0000, 32'h0, 32'h1234_8001, 0);
        check_eq("lh_rdata", res_rdata, 32'hFFFF_8001);

        // LBU zero extension, byte 1
        run_access("lbu", 1'b0, 3'b100, 32'h0000_0101, 32'h0, 32'h0000_C300, 0);
        check_eq("lbu_rdata", res_rdata, 32'h0000_00C3);

        // funct3 011 behaves as a word load
        run_access("lw011", 1'b0, 3'b011, 32'h0000_0008, 32'h0, 32'hDEAD_BEEF, 0);
        check_eq("lw011_rdata", res_rdata, 32'hDEAD_BEEF);
        check_eq("lw011_addr", res_bus_addr, 32'h0000_0008);

        // Timeout: bus never ready
        run_access("timeout", 1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'h1111_1111, -1);
        check_eq("to_err", 32'(res_err), 32'd1);
        check_eq("to_done_cyc", 32'(res_done_cyc), 32'd16);
        check_eq("to_rdata", res_rdata, 32'h0);
        check_eq("to_stall", 32'(res_stall_cycles), 32'd16);
        @(negedge clk);
        check_eq("to_err_pulse", 32'(bus_err), 32'd0);
        check_eq("to_back_idle", 32'(bus_valid), 32'd0);

        // Asynchronous reset in BUSY
        @(negedge clk);
        mem_req = 1'b1;
        memwrite = 1'b0;
        funct3 = 3'b010;
        addr = 32'h0000_0040;
        bus_ready = 1'b0;
        @(negedge clk);
        check_eq("arst_pre_valid", 32'(bus_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        check_eq("arst_valid", 32'(bus_valid), 32'd0);
        check_eq("arst_addr", bus_addr, 32'h0);
        mem_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        $display("access arst: reset asserted during BUSY, bus_valid=%0d", bus_valid);
        run_access("sw", 1'b1, 3'b010, 32'h0000_0010, 32'h1234_5678, 32'h0, 0);
        check_eq("sw_strb", 32'(res_wstrb), 32'hF);
        check_eq("sw_wdata", res_bus_wdata, 32'h1234_5678);
        check_eq("sw_addr", res_bus_addr, 32'h0000_0010);
        check_eq("sw_rdata", res_rdata, 32'h0);

        // Misaligned word load
        run_access("lw_mis", 1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'hCAFE_F00D, 0);
`ifdef LSU_MISALIGN_EN
        check_eq("mis_no_valid", 32'(res_valid_cycles), 32'd0);
        check_eq("mis_flag", 32'(res_mis), 32'd1);
        check_eq("mis_done_cyc", 32'(res_done_cyc), 32'd1);
        check_eq("mis_rdata", res_rdata, 32'h0);
`else
        check_eq("mis_addr", res_bus_addr, 32'h0000_0100);
        check_eq("mis_flag", 32'(res_mis), 32'd0);
        check_eq("mis_done_cyc", 32'(res_done_cyc), 32'd2);
        check_eq("mis_rdata", res_rdata, 32'hCAFE_F00D);
`endif
        @(negedge clk);
        check_eq("mis_pulse", 32'(misalign), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequential data-memory interface sitting directly downstream of `data_path`. It consumes `aluresult` (address) and `writedata` (store data) and returns the load result on `readdata`. It converts the core's single-cycle load/store intent into a valid/ready bus transaction with byte strobes, does load sign/zero extension, and stalls the core while the access is outstanding. A timeout guard ensures a dead bus cannot hang the core.

## Interface
- `TIMEOUT`, default 15: maximum cycles spent waiting for `bus_ready` before the access is aborted with `bus_err`; legal range 1–255.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `mem_req` input 1: current instruction is a load or store; held by the core while `stall` is high.
- `memwrite` input 1: 1 = store, 0 = load; qualified by `mem_req`.
- `funct3` input 3: access size and sign; 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr` input 32: byte address, connected to `aluresult`.
- `wdata` input 32: store data, connected to `writedata`.
- `readdata` output 32: extended load result; valid in DONE and held until the next DONE.
- `stall` output 1: freezes the PC register and register-file write while high.
- `bus_err` output 1: one-cycle pulse in DONE when the access timed out.
- `misalign` output 1: one-cycle pulse in DONE for a misaligned access; constant 0 unless `LSU_MISALIGN_EN` is defined.
- `bus_valid` output 1: request valid.
- `bus_we` output 1: request is a write.
- `bus_addr` output 32: word address, `{addr[31:2],2'b00}`.
- `bus_wdata` output 32: store data shifted to its byte lanes.
- `bus_wstrb` output 4: byte-lane write enables; 0 for loads.
- `bus_ready` input 1: completes the request in any cycle where `bus_valid` is high.
- `bus_rdata` input 32: read word; sampled only when `bus_valid && bus_ready && !bus_we`.

## Operation
- FSM states are IDLE, BUSY and DONE.
  - IDLE: when `mem_req` is high, register `addr`, `funct3`, `memwrite` and the lane-shifted `wdata` and strobe, then go to BUSY.
  - BUSY: `bus_valid` is high and all bus outputs are driven from the registered copies and are stable. If `bus_ready` is high, capture the data and go to DONE. If the wait counter reaches `TIMEOUT`, go to DONE with `bus_err` set.
  - DONE: `stall` is 0 so the core retires the instruction. The next state is always IDLE; `mem_req` seen in DONE is ignored.
- `stall` is combinational: `(state==IDLE && mem_req) || state==BUSY`.
- Store lane rules:
  - SB: `wstrb = 4'b0001 << addr[1:0]`, data is `{4{wdata[7:0]}}`.
  - SH: `wstrb = 4'b0011 << {addr[1],1'b0}`, data is `{2{wdata[15:0]}}`.
  - SW: `wstrb = 4'b1111`.
- Load extraction: the byte is selected by `addr[1:0]` and the half-word by `addr[1]`. B and H are sign-extended; BU and HU are zero-extended. funct3 values 011, 110 and 111 are treated as W.
- A store updates `readdata` to 0 in DONE. A timeout also forces `readdata` to 0.
- The wait counter is 8 bits. It clears on entry to BUSY and increments each BUSY cycle without `bus_ready`. Timeout fires when the counter equals `TIMEOUT-1` and `bus_ready` is low.

## Timing
- Reset values: state IDLE, `bus_valid` 0, `bus_we` 0, `bus_addr` 0, `bus_wdata` 0, `bus_wstrb` 0, `readdata` 0, `bus_err` 0, `misalign` 0, counter 0. `stall` follows `mem_req` while in IDLE.
- Minimum access takes 3 cycles: IDLE (capture), BUSY (`bus_ready` high), DONE. `stall` is high for the first 2 of these.
- With N wait cycles, `stall` is high for 2+N cycles.
- A timeout gives DONE exactly `TIMEOUT`+1 cycles after the IDLE capture cycle.
- Back-to-back accesses: DONE is followed by IDLE, and a new `mem_req` is captured in that IDLE cycle.
- `rst` asserted mid-access: `bus_valid` drops asynchronously and the transaction is abandoned. No response is expected from the bus.

## Configuration
- `LSU_MISALIGN_EN` defined:
  - A misaligned access (H/HU/SH with `addr[0]`=1, or W/SW with `addr[1:0]`≠0) goes from IDLE directly to DONE on the next edge. There is no bus transaction.
  - `misalign` pulses high in DONE and `readdata` is 0.
- `LSU_MISALIGN_EN` undefined:
  - `misalign` is tied 0.
  - Unneeded low address bits are ignored: H uses `addr[1]` only, W uses neither bit.
  - Every access goes to the bus.

## Test plan
- LB at `addr=0x103`, `bus_rdata=0x80FF_1234`, `bus_ready` in the first BUSY cycle → `bus_addr=0x100`, `readdata=0xFFFF_FF80` in cycle 3, `stall` high for 2 cycles.
- LHU at `0x202`, `bus_rdata=0xBEEF_0000`, 3 wait cycles → `readdata=0x0000_BEEF`, `stall` high for 5 cycles.
- SB at `0x007`, `wdata=0x0000_00A5` → `bus_we=1`, `bus_wstrb=4'b1000`, `bus_wdata=0xA5A5_A5A5`, `readdata=0`.
- LW with `bus_ready` held low, `TIMEOUT=15` → `bus_err` pulses exactly once, 16 cycles after capture; `readdata=0`; FSM returns to IDLE.
- `rst` low during BUSY → `bus_valid` is 0 immediately; after release, a fresh SW at `0x10` with `wdata=0x1234_5678` completes with `bus_wstrb=4'b1111`.
- With `LSU_MISALIGN_EN`, LW at `0x102` → no `bus_valid`, `misalign` pulses in cycle 2; without the macro → `bus_addr=0x100` and the access completes normally.
